load_store_unit: RTL and testbench

Memory-stage load/store unit. It sits between the pipeline's Memory stage (address, store data, funct3, MemWrite outputs) and a single-ported data bus with a req/ack handshake. It does four things:
- formats byte, halfword and word stores into lane-aligned data plus byte enables;
- sign- or zero-extends loads into ReadDataM, which feeds the Memory/Writeback pipeline register;
- stalls the pipeline while a bus access is in flight;
- flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: Memory-stage load/store unit sitting between the M stage
// and a single-ported req/ack data bus.
//   clk, reset         : clock, asynchronous active-low reset
//   MemWriteM/MemReadM : store / load request from the M stage
//   funct3M            : size/sign (B, H, W, BU, HU)
//   ALUResultM         : byte address
//   WriteDataM         : right-justified store data
//   ReadDataM          : formatted load data (valid in the DONE cycle)
//   StallM             : holds F/D/E/M while a bus access is in flight
//   ErrM               : 00 ok, 01 misaligned, 10 illegal, 11 bus timeout
//   bus_*              : word-addressed bus with byte enables, req/ack
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic [1:0]  ErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    k_q, k_d;
  logic          ld_q, ld_d;

  logic        req, illegal, misalign;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt, shifted, rd_fmt;
  logic        stall;
  logic [1:0]  err_o;
  logic [31:0] rd_o;

  assign req = MemWriteM | MemReadM;

  // Illegal takes priority; alignment is only judged for legal accesses.
  always_comb begin
    illegal = MemWriteM & MemReadM;
    if (MemReadM && (funct3M == 3'b011 || funct3M == 3'b110 || funct3M == 3'b111))
      illegal = 1'b1;
    if (MemWriteM && !(funct3M == 3'b000 || funct3M == 3'b001 || funct3M == 3'b010))
      illegal = 1'b1;
    misalign = req && !illegal &&
               ((funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00));
  end

  // Lane placement; loads reuse the enable pattern but send no data.
  always_comb begin
    be_fmt    = 4'b0000;
    wdata_fmt = 32'h0;
    case (funct3M[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << ALUResultM[1:0];
        wdata_fmt = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << ALUResultM[1:0];
        wdata_fmt = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        be_fmt    = 4'b1111;
        wdata_fmt = WriteDataM;
      end
      default: ;
    endcase
    if (!MemWriteM) wdata_fmt = 32'h0;
  end

  // Load extraction from the word captured in REQ, using latched f3/k.
  always_comb begin
    shifted = rdata_q >> {k_q, 3'b000};
    case (f3_q)
      3'b000:  rd_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  rd_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  rd_fmt = {24'h0, shifted[7:0]};
      3'b101:  rd_fmt = {16'h0, shifted[15:0]};
      default: rd_fmt = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    f3_d        = f3_q;
    k_d         = k_q;
    ld_d        = ld_q;
    stall       = 1'b0;
    err_o       = 2'b00;
    rd_o        = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (illegal)       err_o = 2'b10;
          else if (misalign) err_o = 2'b01;
          else begin
            stall       = 1'b1;
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWriteM;
            bus_addr_d  = {ALUResultM[31:2], 2'b00};
            bus_be_d    = be_fmt;
            bus_wdata_d = wdata_fmt;
            cnt_d       = '0;
            err_d       = 2'b00;
            f3_d        = funct3M;
            k_d         = ALUResultM[1:0];
            ld_d        = MemReadM;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // ack wins over a coincident timeout
        if (bus_ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
          err_d     = 2'b00;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d   = 32'h0;
          bus_req_d = 1'b0;
          err_d     = 2'b11;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        err_o   = err_q;
        rd_o    = ld_q ? rd_fmt : 32'h0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      rdata_q     <= 32'h0;
      cnt_q       <= '0;
      err_q       <= 2'b00;
      f3_q        <= 3'b000;
      k_q         <= 2'b00;
      ld_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      f3_q        <= f3_d;
      k_q         <= k_d;
      ld_q        <= ld_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held, even if the
  // M stage keeps presenting a request.
  assign StallM    = reset & stall;
  assign ErrM      = reset ? err_o : 2'b00;
  assign ReadDataM = reset ? rd_o : 32'h0;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM;
  logic [1:0]  ErrM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .ErrM(ErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          stall;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          len;   // expected REQ cycles, -1 = don't check
    int          gap;   // expected negedges since previous response, -1 = don't check
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int checks = 0, errors = 0;
  int resp_cnt = 0, cyc = 0, last_resp_cyc = 0;
  int ack_wait = 0;  // wait states before ack, -1 = never
  logic [31:0] mem [int unsigned];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // Bus slave: ack after ack_wait REQ cycles, memory with byte-enable writes.
  initial begin
    int wcnt;
    logic [31:0] w;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req && reset) begin
        if (ack_wait >= 0 && wcnt == ack_wait) begin
          w = mem.exists(bus_addr >> 2) ? mem[bus_addr >> 2] : 32'h0;
          bus_rdata = w;
          if (bus_we) begin
            for (int b = 0; b < 4; b++)
              if (bus_be[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
            mem[bus_addr >> 2] = w;
          end
          bus_ack = 1'b1;
        end else bus_ack = 1'b0;
        wcnt++;
      end else begin
        bus_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: bus-side and pipeline-side scoreboards.
  initial begin
    logic prev_req;
    int   stall_cnt, req_len;
    bus_t cur;
    bus_t snap;
    resp_t r;
    prev_req = 1'b0; stall_cnt = 0; req_len = 0;
    cur = '{1'b0, 32'h0, 4'h0, 32'h0, -1, -1};
    snap = cur;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_req = 1'b0; stall_cnt = 0; req_len = 0;
      end else begin
        if (bus_req && !prev_req) begin
          if (bq.size() == 0) begin
            chk("unexpected_bus_req", 32'(bus_req), 32'd0);
            cur.len = -1;
          end else begin
            cur = bq.pop_front();
            chk("bus_we", 32'(bus_we), 32'(cur.we));
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_be", 32'(bus_be), 32'(cur.be));
            chk("bus_wdata", bus_wdata, cur.wdata);
            if (cur.gap >= 0) chk("b2b_gap", 32'(cyc - last_resp_cyc), 32'(cur.gap));
          end
          snap = '{bus_we, bus_addr, bus_be, bus_wdata, 0, 0};
          req_len = 0;
        end
        if (bus_req) begin
          req_len++;
          if (prev_req) begin
            chk("req_hold_addr", bus_addr, snap.addr);
            chk("req_hold_ctl", {27'h0, bus_we, bus_be}, {27'h0, snap.we, snap.be});
            chk("req_hold_wdata", bus_wdata, snap.wdata);
          end
        end
        if (!bus_req && prev_req && cur.len >= 0)
          chk("req_len", 32'(req_len), 32'(cur.len));
        prev_req = bus_req;

        if ((MemReadM || MemWriteM) && !StallM) begin
          if (rq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else begin
            r = rq.pop_front();
            chk("ErrM", 32'(ErrM), 32'(r.err));
            chk("ReadDataM", ReadDataM, r.rdata);
            chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
          end
          resp_cnt++;
          last_resp_cyc = cyc;
          stall_cnt = 0;
        end else if (StallM) stall_cnt++;
      end
    end
  end

  task automatic bexp(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input int len, input int gap);
    bus_t b;
    b = '{we, addr, be, wdata, len, gap};
    bq.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the response cycle.
  task automatic issue(input logic we, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] err, input logic [31:0] rdata, input int stall);
    resp_t r;
    int start;
    bit seen;
    r = '{err, rdata, stall};
    rq.push_back(r);
    start = resp_cnt;
    MemWriteM = we; MemReadM = rd; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (resp_cnt != start) seen = 1;
    end
    if (!seen) chk("resp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_inputs();
    MemWriteM = 0; MemReadM = 0; funct3M = 3'b000; ALUResultM = 0; WriteDataM = 0;
  endtask

  initial begin
    reset = 1'b0;
    MemWriteM = 0; MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h300; WriteDataM = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_ErrM", 32'(ErrM), 32'd0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata_be", {bus_wdata[27:0], bus_be}, 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: SB 0x103, zero wait
    ack_wait = 0;
    bexp(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1, -1);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h000000A5, 2'b00, 32'h0, 2);
    idle_inputs(); @(posedge clk); #1;

    // 2: LB / LBU 0x102, 3 wait states
    mem[32'h100 >> 2] = 32'h12F45678;
    ack_wait = 3;
    bexp(1'b0, 32'h100, 4'b0100, 32'h0, 4, -1);
    issue(1'b0, 1'b1, 3'b000, 32'h102, 32'hDEADBEEF, 2'b00, 32'hFFFFFFF4, 5);
    idle_inputs(); @(posedge clk); #1;
    bexp(1'b0, 32'h100, 4'b0100, 32'h0, 4, -1);
    issue(1'b0, 1'b1, 3'b100, 32'h102, 32'h0, 2'b00, 32'h000000F4, 5);
    idle_inputs(); @(posedge clk); #1;

    // 3: LHU 0x202, then misaligned LH 0x201
    mem[32'h200 >> 2] = 32'h8001ABCD;
    ack_wait = 0;
    bexp(1'b0, 32'h200, 4'b1100, 32'h0, 1, -1);
    issue(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, 2'b00, 32'h00008001, 2);
    issue(1'b0, 1'b1, 3'b001, 32'h201, 32'h0, 2'b01, 32'h0, 0);
    idle_inputs(); @(posedge clk); #1;

    // 4: LW 0x300 never acked, then both read and write
    ack_wait = -1;
    bexp(1'b0, 32'h300, 4'b1111, 32'h0, 16, -1);
    issue(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 2'b11, 32'h0, 17);
    issue(1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 2'b10, 32'h0, 0);
    // illegal store size, illegal load size, misaligned word
    issue(1'b1, 1'b0, 3'b100, 32'h300, 32'h0, 2'b10, 32'h0, 0);
    issue(1'b0, 1'b1, 3'b110, 32'h300, 32'h0, 2'b10, 32'h0, 0);
    issue(1'b0, 1'b1, 3'b010, 32'h302, 32'h0, 2'b01, 32'h0, 0);
    idle_inputs(); @(posedge clk); #1;

    // SH into upper half, one wait state
    ack_wait = 1;
    bexp(1'b1, 32'h500, 4'b1100, 32'h5A3C5A3C, 2, -1);
    issue(1'b1, 1'b0, 3'b001, 32'h502, 32'h12345A3C, 2'b00, 32'h0, 3);

    // 5: back-to-back SW then LW at 0x10; the load's request is one IDLE
    // cycle after the store's DONE, i.e. two monitor samples later.
    bexp(1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 2, -1);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'hCAFEF00D, 2'b00, 32'h0, 3);
    ack_wait = 0;
    bexp(1'b0, 32'h10, 4'b1111, 32'h0, 1, 2);
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 2'b00, 32'hCAFEF00D, 2);
    idle_inputs(); @(posedge clk); #1;

    // 6: reset pulled low mid-wait
    ack_wait = -1;
    bexp(1'b0, 32'h400, 4'b1111, 32'h0, -1, -1);
    MemWriteM = 0; MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h400; WriteDataM = 0;
    repeat (3) @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_StallM", 32'(StallM), 32'd0);
    chk("midrst_ErrM", 32'(ErrM), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem[32'h400 >> 2] = 32'h01234567;
    ack_wait = 2;
    bexp(1'b0, 32'h400, 4'b1111, 32'h0, 3, -1);
    issue(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 2'b00, 32'h01234567, 4);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("bus_queue_drained", 32'(bq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
